// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter: default geometry and the fixed
// source index assignment of the result producers.
package cdb_arbiter_pkg;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSB = 1;
    localparam int SRC_BRU = 2;

    localparam int NSRC_DEF   = 3;
    localparam int DEPTH_DEF  = 2;
    localparam int TAG_W_DEF  = 5;
    localparam int DATA_W_DEF = 32;

    // Round-robin successor of a source index, wrapping at n.
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_src_fifo.sv
// Small per-producer FIFO holding (ROB tag, value) pairs waiting for the CDB.
// Head entry is presented combinationally so the arbiter can register it on pop.
module cdb_src_fifo #(
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [TAG_W-1:0]  push_tag,
    input  logic [DATA_W-1:0] push_data,
    output logic [TAG_W-1:0]  head_tag,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_reg]  <= push_tag;
            data_mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !pop)
                count_reg <= count_reg + CNT_W'(1);
            else if (pop && !push)
                count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign head_tag  = tag_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the single ROB result-write path (the CDB)
// between the ALU, LSB and branch unit, one registered broadcast per cycle.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NSRC   = NSRC_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   clear_in,
    input  logic [NSRC-1:0]        src_valid_in,
    input  logic [NSRC*TAG_W-1:0]  src_tag_in,
    input  logic [NSRC*DATA_W-1:0] src_data_in,
    output logic [NSRC-1:0]        src_ready_out,
    output logic                   cdb_valid_out,
    output logic [TAG_W-1:0]       cdb_tag_out,
    output logic [DATA_W-1:0]      cdb_data_out,
    output logic [SRC_W-1:0]       cdb_src_out,
    output logic                   busy_out
);
    logic [NSRC-1:0]   full;
    logic [NSRC-1:0]   empty;
    logic [NSRC-1:0]   push;
    logic [NSRC-1:0]   pop;
    logic [TAG_W-1:0]  head_tag  [NSRC];
    logic [DATA_W-1:0] head_data [NSRC];

    logic              flush;
    logic              has_winner;
    logic [SRC_W-1:0]  winner;
    logic [SRC_W-1:0]  rr_ptr_reg;
    logic              cdb_valid_reg;
    logic [TAG_W-1:0]  cdb_tag_reg;
    logic [DATA_W-1:0] cdb_data_reg;
    logic [SRC_W-1:0]  cdb_src_reg;

    assign flush = rdy_in && clear_in;

    // Ready looks only at the registered count, never at this cycle's pop.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            assign src_ready_out[gi] = rdy_in && !full[gi];
            assign push[gi] = rdy_in && !clear_in && !rst_in &&
                              src_valid_in[gi] && !full[gi];
            assign pop[gi]  = rdy_in && !clear_in && !rst_in &&
                              has_winner && (winner == SRC_W'(gi));

            cdb_src_fifo #(
                .DEPTH (DEPTH),
                .TAG_W (TAG_W),
                .DATA_W(DATA_W)
            ) u_fifo (
                .clk      (clk_in),
                .srst     (rst_in),
                .flush    (flush),
                .push     (push[gi]),
                .pop      (pop[gi]),
                .push_tag (src_tag_in[gi*TAG_W +: TAG_W]),
                .push_data(src_data_in[gi*DATA_W +: DATA_W]),
                .head_tag (head_tag[gi]),
                .head_data(head_data[gi]),
                .full     (full[gi]),
                .empty    (empty[gi])
            );
        end
    endgenerate

    // Scan from the far end back toward rr_ptr so the closest non-empty source wins.
    always_comb begin
        has_winner = 1'b0;
        winner     = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NSRC) idx = idx - NSRC;
            if (!empty[idx]) begin
                has_winner = 1'b1;
                winner     = SRC_W'(idx);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cdb_valid_reg <= 1'b0;
            cdb_tag_reg   <= '0;
            cdb_data_reg  <= '0;
            cdb_src_reg   <= '0;
            rr_ptr_reg    <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                cdb_valid_reg <= 1'b0;
                rr_ptr_reg    <= '0;
            end else if (has_winner) begin
                cdb_valid_reg <= 1'b1;
                cdb_tag_reg   <= head_tag[winner];
                cdb_data_reg  <= head_data[winner];
                cdb_src_reg   <= winner;
                rr_ptr_reg    <= SRC_W'(rr_next(int'(winner), NSRC));
            end else begin
                cdb_valid_reg <= 1'b0;
            end
        end
    end

    assign cdb_valid_out = cdb_valid_reg;
    assign cdb_tag_out   = cdb_tag_reg;
    assign cdb_data_out  = cdb_data_reg;
    assign cdb_src_out   = cdb_src_reg;
    assign busy_out      = |(~empty);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a vector table for single-edge behaviour
// plus a scoreboarded two-source streaming sequence for fairness/backpressure.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NSRC   = 3;
    localparam int DEPTH  = 2;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;

    logic                   clk = 1'b0;
    logic                   rst_in;
    logic                   rdy_in;
    logic                   clear_in;
    logic [NSRC-1:0]        src_valid_in;
    logic [NSRC*TAG_W-1:0]  src_tag_in;
    logic [NSRC*DATA_W-1:0] src_data_in;
    logic [NSRC-1:0]        src_ready_out;
    logic                   cdb_valid_out;
    logic [TAG_W-1:0]       cdb_tag_out;
    logic [DATA_W-1:0]      cdb_data_out;
    logic [1:0]             cdb_src_out;
    logic                   busy_out;

    int compared   = 0;
    int mismatched = 0;

    cdb_arbiter #(
        .NSRC  (NSRC),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .clear_in     (clear_in),
        .src_valid_in (src_valid_in),
        .src_tag_in   (src_tag_in),
        .src_data_in  (src_data_in),
        .src_ready_out(src_ready_out),
        .cdb_valid_out(cdb_valid_out),
        .cdb_tag_out  (cdb_tag_out),
        .cdb_data_out (cdb_data_out),
        .cdb_src_out  (cdb_src_out),
        .busy_out     (busy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, rdy, clr;
        logic [2:0]  valid;
        logic [14:0] tags;
        logic [95:0] datas;
        logic        ev;
        logic [4:0]  etag;
        logic [31:0] edata;
        logic [1:0]  esrc;
        logic [2:0]  erdy;
        logic        ebusy;
    } vec_t;

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] data;
    } ent_t;

    vec_t vecs[$];
    ent_t q0[$];
    ent_t q1[$];

    function automatic vec_t mk(input logic rst, input logic rdy, input logic clr,
                                input logic [2:0] valid,
                                input int t0, input int d0, input int t1, input int d1,
                                input int t2, input int d2,
                                input logic ev, input int etag, input int edata,
                                input int esrc, input logic [2:0] erdy, input logic ebusy);
        vec_t m;
        m.rst = rst; m.rdy = rdy; m.clr = clr; m.valid = valid;
        m.tags  = {5'(t2), 5'(t1), 5'(t0)};
        m.datas = {32'(d2), 32'(d1), 32'(d0)};
        m.ev = ev; m.etag = 5'(etag); m.edata = 32'(edata);
        m.esrc = 2'(esrc); m.erdy = erdy; m.ebusy = ebusy;
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference round-robin pick over queue occupancies; -1 when nothing is queued.
    function automatic int pick(input int rr, input int s0, input int s1, input int s2);
        int sz[3];
        sz[0] = s0; sz[1] = s1; sz[2] = s2;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (rr + k) % 3;
            if (sz[idx] > 0) return idx;
        end
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_m;
        int seq0, seq1, del0, del1;
        logic low0, low1;

        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
        src_valid_in = '0; src_tag_in = '0; src_data_in = '0;

        //                rst rdy clr valid   t0 d0     t1 d1     t2 d2      ev tag data  src rdy    busy
        // reset state
        vecs.push_back(mk(1, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      0, 0,  0,     0, 3'b111, 0));
        vecs.push_back(mk(1, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      0, 0,  0,     0, 3'b111, 0));
        // single push, one-cycle pulse two edges later
        vecs.push_back(mk(0, 1, 0, 3'b001,  3, 'h11,  0, 0,     0, 0,      0, 0,  0,     0, 3'b111, 1));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      1, 3,  'h11,  0, 3'b111, 0));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      0, 3,  'h11,  0, 3'b111, 0));
        // simultaneous pushes from rr_ptr = 0
        vecs.push_back(mk(1, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      0, 0,  0,     0, 3'b111, 0));
        vecs.push_back(mk(0, 1, 0, 3'b111,  1, 'hA,   2, 'hB,   4, 'hC,    0, 0,  0,     0, 3'b111, 1));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      1, 1,  'hA,   0, 3'b111, 1));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      1, 2,  'hB,   1, 3'b111, 1));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      1, 4,  'hC,   2, 3'b111, 0));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      0, 4,  'hC,   2, 3'b111, 0));
        // rr_ptr wrapped to 0: src1 must beat src2
        vecs.push_back(mk(0, 1, 0, 3'b110,  0, 0,     7, 'h71,  8, 'h82,   0, 4,  'hC,   2, 3'b111, 1));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      1, 7,  'h71,  1, 3'b111, 1));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      1, 8,  'h82,  2, 3'b111, 0));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      0, 8,  'h82,  2, 3'b111, 0));
        // flush with src1 full and a src2 push in the clear cycle
        vecs.push_back(mk(0, 1, 0, 3'b011,  9, 'h91,  10, 'hA0, 0, 0,      0, 8,  'h82,  2, 3'b111, 1));
        vecs.push_back(mk(0, 1, 0, 3'b010,  0, 0,     11, 'hB1, 0, 0,      1, 9,  'h91,  0, 3'b101, 1));
        vecs.push_back(mk(0, 1, 1, 3'b110,  0, 0,     30, 'h30, 12, 'hC2,  0, 9,  'h91,  0, 3'b111, 0));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      0, 9,  'h91,  0, 3'b111, 0));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      0, 9,  'h91,  0, 3'b111, 0));
        // reset with four entries pending
        vecs.push_back(mk(0, 1, 0, 3'b111,  13, 'hD0, 14, 'hE0, 15, 'hF0,  0, 9,  'h91,  0, 3'b111, 1));
        vecs.push_back(mk(0, 1, 0, 3'b110,  0, 0,     16, 'h16, 17, 'h17,  1, 13, 'hD0,  0, 3'b001, 1));
        vecs.push_back(mk(1, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      0, 0,  0,     0, 3'b111, 0));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      0, 0,  0,     0, 3'b111, 0));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      0, 0,  0,     0, 3'b111, 0));
        // stall: rdy low freezes everything, src0 held valid is not taken
        vecs.push_back(mk(0, 1, 0, 3'b011,  20, 'h20, 21, 'h21, 0, 0,      0, 0,  0,     0, 3'b111, 1));
        vecs.push_back(mk(0, 1, 0, 3'b001,  22, 'h22, 0, 0,     0, 0,      1, 20, 'h20,  0, 3'b111, 1));
        vecs.push_back(mk(0, 0, 0, 3'b001,  23, 'h23, 0, 0,     0, 0,      1, 20, 'h20,  0, 3'b000, 1));
        vecs.push_back(mk(0, 0, 0, 3'b001,  23, 'h23, 0, 0,     0, 0,      1, 20, 'h20,  0, 3'b000, 1));
        vecs.push_back(mk(0, 0, 0, 3'b001,  23, 'h23, 0, 0,     0, 0,      1, 20, 'h20,  0, 3'b000, 1));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      1, 21, 'h21,  1, 3'b111, 1));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      1, 22, 'h22,  0, 3'b111, 0));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      0, 22, 'h22,  0, 3'b111, 0));
        // clear is ignored while rdy is low
        vecs.push_back(mk(0, 1, 0, 3'b100,  0, 0,     0, 0,     25, 'h25,  0, 22, 'h22,  0, 3'b111, 1));
        vecs.push_back(mk(0, 0, 1, 3'b000,  0, 0,     0, 0,     0, 0,      0, 22, 'h22,  0, 3'b000, 1));
        vecs.push_back(mk(0, 1, 0, 3'b000,  0, 0,     0, 0,     0, 0,      1, 25, 'h25,  2, 3'b111, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_in       = vecs[i].rst;
            rdy_in       = vecs[i].rdy;
            clear_in     = vecs[i].clr;
            src_valid_in = vecs[i].valid;
            src_tag_in   = vecs[i].tags;
            src_data_in  = vecs[i].datas;
            @(posedge clk);
            #1;
            $display("vec %0d: rst=%0b rdy=%0b clr=%0b valid=%03b -> cdb v=%0b tag=%0d data=%0h src=%0d ready=%03b busy=%0b",
                     i, vecs[i].rst, vecs[i].rdy, vecs[i].clr, vecs[i].valid,
                     cdb_valid_out, cdb_tag_out, cdb_data_out, cdb_src_out, src_ready_out, busy_out);
            chk($sformatf("vec%0d cdb_valid", i), 32'(cdb_valid_out), 32'(vecs[i].ev));
            chk($sformatf("vec%0d cdb_tag", i),   32'(cdb_tag_out),   32'(vecs[i].etag));
            chk($sformatf("vec%0d cdb_data", i),  cdb_data_out,       vecs[i].edata);
            chk($sformatf("vec%0d cdb_src", i),   32'(cdb_src_out),   32'(vecs[i].esrc));
            chk($sformatf("vec%0d ready", i),     32'(src_ready_out), 32'(vecs[i].erdy));
            chk($sformatf("vec%0d busy", i),      32'(busy_out),      32'(vecs[i].ebusy));
        end

        // ALU and LSB stream for 10 cycles, then drain; rr_ptr is 0 after the table.
        rr_m = 0; seq0 = 0; seq1 = 0; del0 = 0; del1 = 0; low0 = 1'b0; low1 = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            logic acc0, acc1;
            int   w;
            @(negedge clk);
            chk($sformatf("stream c%0d ready0", cyc), 32'(src_ready_out[SRC_ALU]), 32'(q0.size() < DEPTH));
            chk($sformatf("stream c%0d ready1", cyc), 32'(src_ready_out[SRC_LSB]), 32'(q1.size() < DEPTH));
            if (!src_ready_out[SRC_ALU]) low0 = 1'b1;
            if (!src_ready_out[SRC_LSB]) low1 = 1'b1;
            rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
            src_valid_in = (cyc < 10) ? 3'b011 : 3'b000;
            src_tag_in   = {5'd0, 5'(16 + seq1), 5'(seq0)};
            src_data_in  = {32'd0, 32'(32'h2000 + seq1), 32'(32'h1000 + seq0)};
            #1;
            acc0 = src_valid_in[SRC_ALU] && src_ready_out[SRC_ALU];
            acc1 = src_valid_in[SRC_LSB] && src_ready_out[SRC_LSB];
            @(posedge clk);
            #1;
            w = pick(rr_m, q0.size(), q1.size(), 0);
            $display("stream c%0d: acc0=%0b acc1=%0b -> cdb v=%0b tag=%0d data=%0h src=%0d (model src %0d)",
                     cyc, acc0, acc1, cdb_valid_out, cdb_tag_out, cdb_data_out, cdb_src_out, w);
            if (w < 0) begin
                chk($sformatf("stream c%0d idle valid", cyc), 32'(cdb_valid_out), 32'd0);
            end else begin
                ent_t e;
                e = (w == 0) ? q0.pop_front() : q1.pop_front();
                if (w == 0) del0++; else del1++;
                chk($sformatf("stream c%0d valid", cyc), 32'(cdb_valid_out), 32'd1);
                chk($sformatf("stream c%0d src", cyc),   32'(cdb_src_out),   32'(w));
                chk($sformatf("stream c%0d tag", cyc),   32'(cdb_tag_out),   32'(e.tag));
                chk($sformatf("stream c%0d data", cyc),  cdb_data_out,       e.data);
                rr_m = rr_next(w, NSRC);
            end
            if (acc0) begin q0.push_back({5'(seq0), 32'(32'h1000 + seq0)}); seq0++; end
            if (acc1) begin q1.push_back({5'(16 + seq1), 32'(32'h2000 + seq1)}); seq1++; end
        end
        chk("stream leftover src0", 32'(q0.size()), 32'd0);
        chk("stream leftover src1", 32'(q1.size()), 32'd0);
        chk("stream delivered src0", 32'(del0), 32'(seq0));
        chk("stream delivered src1", 32'(del1), 32'(seq1));
        chk("stream src0 backpressured", 32'(low0), 32'd1);
        chk("stream src1 backpressured", 32'(low1), 32'd1);
        chk("stream idle busy", 32'(busy_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
